// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and helpers for the stream demultiplexer
package stream_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

  // Width of the channel select; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// rtl/stream_slot.sv - one-entry registered output slot with drain/reload
module stream_slot #(
  parameter int WIDTH_DATA = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH_DATA-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic [WIDTH_DATA-1:0] data,
  output logic                  valid,
  output logic                  last,
  output logic                  free
);

  // A full slot can take a new beat in the same cycle it drains.
  assign free = ~valid | ready;

  // Load has priority over drain; data and last hold after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1:N valid/ready stream demultiplexer with per-packet route lock
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_OUTPUTS = 8,
  parameter int WIDTH_DATA  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [WIDTH_DATA-1:0]                   in_data,
  input  logic                                    in_valid,
  input  logic                                    in_last,
  output logic                                    in_ready,
  input  logic [sel_width(NUM_OUTPUTS)-1:0]       sel,
  output logic [NUM_OUTPUTS-1:0][WIDTH_DATA-1:0]  out_data,
  output logic [NUM_OUTPUTS-1:0]                  out_valid,
  output logic [NUM_OUTPUTS-1:0]                  out_last,
  input  logic [NUM_OUTPUTS-1:0]                  out_ready,
  output logic                                    locked,
  output logic                                    drop
);

  localparam int SW = sel_width(NUM_OUTPUTS);

  demux_state_t           state;
  logic [SW-1:0]          route;
  logic [SW-1:0]          eff_route;
  logic [NUM_OUTPUTS-1:0] hit;
  logic [NUM_OUTPUTS-1:0] slot_free;
  logic [NUM_OUTPUTS-1:0] load;
  logic                   route_ok;
  logic                   accept;

  // The first beat of a packet steers by sel; later beats use the latched route.
  assign eff_route = (state == IDLE) ? sel : route;

  // One-hot decode of the route; an all-zero result means out of range.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      hit[k] = (eff_route == SW'(k));
    end
  end

  assign route_ok = |hit;
  // Out-of-range beats are always taken so the drop path never stalls.
  assign in_ready = route_ok ? |(hit & slot_free) : 1'b1;
  assign accept   = in_valid & in_ready;
  assign load     = {NUM_OUTPUTS{in_valid}} & hit & slot_free;
  assign locked   = (state == LOCKED);

  // Packet tracking, route latch and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      route <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= accept & ~route_ok;
      case (state)
        IDLE: begin
          if (accept && !in_last) begin
            route <= sel;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_slot
    stream_slot #(
      .WIDTH_DATA(WIDTH_DATA)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (out_ready[g]),
      .data      (out_data[g]),
      .valid     (out_valid[g]),
      .last      (out_last[g]),
      .free      (slot_free[g])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed table-driven bench for stream_demux
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic [7:0]      d8_in;
  logic            v8_in, l8_in, r8_in;
  logic [2:0]      s8;
  logic [7:0][7:0] d8_out;
  logic [7:0]      v8_out, l8_out, r8_out;
  logic            lk8, dr8;

  // 6-channel instance (has out-of-range routes)
  logic [7:0]      d6_in;
  logic            v6_in, l6_in, r6_in;
  logic [2:0]      s6;
  logic [5:0][7:0] d6_out;
  logic [5:0]      v6_out, l6_out, r6_out;
  logic            lk6, dr6;

  stream_demux #(.NUM_OUTPUTS(8), .WIDTH_DATA(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(d8_in), .in_valid(v8_in), .in_last(l8_in),
    .in_ready(r8_in), .sel(s8), .out_data(d8_out), .out_valid(v8_out),
    .out_last(l8_out), .out_ready(r8_out), .locked(lk8), .drop(dr8)
  );

  stream_demux #(.NUM_OUTPUTS(6), .WIDTH_DATA(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(d6_in), .in_valid(v6_in), .in_last(l6_in),
    .in_ready(r6_in), .sel(s6), .out_data(d6_out), .out_valid(v6_out),
    .out_last(l6_out), .out_ready(r6_out), .locked(lk6), .drop(dr6)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
    logic       exp_ready;
    logic [7:0] exp_valid;
    int         exp_chan;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_locked;
  } vec_t;

  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [2:0] s, input logic [7:0] d, input logic l, input logic v);
    s8 = s; d8_in = d; l8_in = l; v8_in = v;
  endtask

  task automatic drive6(input logic [2:0] s, input logic [7:0] d, input logic l, input logic v);
    s6 = s; d6_in = d; l6_in = l; v6_in = v;
  endtask

  initial begin
    // routing sweep: single-beat packets to every channel
    for (int s = 0; s < 8; s++) begin
      vecs[s] = '{sel: 3'(s), data: 8'h10 + 8'(s), last: 1'b1, exp_ready: 1'b1,
                  exp_valid: 8'(1 << s), exp_chan: s, exp_data: 8'h10 + 8'(s),
                  exp_last: 1'b1, exp_locked: 1'b0};
    end
    // packet lock: first beat to 3, later beats present sel=5 which must be ignored
    vecs[8]  = '{3'd3, 8'hA0, 1'b0, 1'b1, 8'h08, 3, 8'hA0, 1'b0, 1'b1};
    vecs[9]  = '{3'd5, 8'hA1, 1'b0, 1'b1, 8'h08, 3, 8'hA1, 1'b0, 1'b1};
    vecs[10] = '{3'd5, 8'hA2, 1'b0, 1'b1, 8'h08, 3, 8'hA2, 1'b0, 1'b1};
    vecs[11] = '{3'd5, 8'hA3, 1'b1, 1'b1, 8'h08, 3, 8'hA3, 1'b1, 1'b0};

    drive8(3'd0, 8'h00, 1'b0, 1'b0);
    drive6(3'd0, 8'h00, 1'b0, 1'b0);
    r8_out = 8'hFF;
    r6_out = 6'h3F;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v8_out), 32'h0);
    chk("rst_data3", 32'(d8_out[3]), 32'h0);
    chk("rst_locked", 32'(lk8), 32'h0);
    chk("rst_drop", 32'(dr8), 32'h0);
    rst_n = 1'b1;
    tick();

    // table: routing sweep and packet lock
    for (int i = 0; i < 12; i++) begin
      drive8(vecs[i].sel, vecs[i].data, vecs[i].last, 1'b1);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(r8_in), 32'(vecs[i].exp_ready));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(v8_out), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data", i), 32'(d8_out[vecs[i].exp_chan]), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_last", i), 32'(l8_out[vecs[i].exp_chan]), 32'(vecs[i].exp_last));
      chk($sformatf("v%0d_locked", i), 32'(lk8), 32'(vecs[i].exp_locked));
      chk($sformatf("v%0d_drop", i), 32'(dr8), 32'h0);
    end
    drive8(3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("idle_drained", 32'(v8_out), 32'h0);

    // backpressure on channel 2
    r8_out = 8'hFB;
    drive8(3'd2, 8'hB0, 1'b1, 1'b1);
    #1;
    chk("bp_first_ready", 32'(r8_in), 32'h1);
    tick();
    chk("bp_first_held", 32'(v8_out), 32'h04);
    drive8(3'd2, 8'hB1, 1'b1, 1'b1);
    #1;
    chk("bp_second_stalled", 32'(r8_in), 32'h0);
    tick();
    chk("bp_still_b0", 32'(d8_out[2]), 32'hB0);
    r8_out = 8'hFF;
    #1;
    chk("bp_release_ready", 32'(r8_in), 32'h1);
    tick();
    chk("bp_no_bubble_valid", 32'(v8_out), 32'h04);
    chk("bp_no_bubble_data", 32'(d8_out[2]), 32'hB1);
    drive8(3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("bp_drained", 32'(v8_out), 32'h0);

    // independence: channel 1 stalled full, channel 6 still flows
    r8_out = 8'hFD;
    drive8(3'd1, 8'hC0, 1'b1, 1'b1);
    tick();
    drive8(3'd6, 8'hC1, 1'b1, 1'b1);
    #1;
    chk("ind_ready6", 32'(r8_in), 32'h1);
    tick();
    chk("ind_valid", 32'(v8_out), 32'h42);
    chk("ind_data6", 32'(d8_out[6]), 32'hC1);
    chk("ind_data1", 32'(d8_out[1]), 32'hC0);
    drive8(3'd0, 8'h00, 1'b0, 1'b0);
    r8_out = 8'hFF;
    tick();
    chk("ind_drained", 32'(v8_out), 32'h0);

    // out-of-range route on the 6-channel instance
    drive6(3'd7, 8'hE0, 1'b0, 1'b1);
    #1;
    chk("oor_ready0", 32'(r6_in), 32'h1);
    tick();
    chk("oor_drop0", 32'(dr6), 32'h1);
    chk("oor_valid0", 32'(v6_out), 32'h0);
    chk("oor_locked0", 32'(lk6), 32'h1);
    drive6(3'd0, 8'hE1, 1'b1, 1'b1);
    #1;
    chk("oor_ready1", 32'(r6_in), 32'h1);
    tick();
    chk("oor_drop1", 32'(dr6), 32'h1);
    chk("oor_valid1", 32'(v6_out), 32'h0);
    chk("oor_locked1", 32'(lk6), 32'h0);
    drive6(3'd0, 8'h5A, 1'b1, 1'b1);
    tick();
    chk("oor_after_drop", 32'(dr6), 32'h0);
    chk("oor_after_valid", 32'(v6_out), 32'h01);
    chk("oor_after_data", 32'(d6_out[0]), 32'h5A);
    drive6(3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("oor_idle_drop", 32'(dr6), 32'h0);

    // asynchronous reset mid-packet
    r8_out = 8'hEF;
    drive8(3'd4, 8'hD0, 1'b0, 1'b1);
    tick();
    r8_out = 8'hFF;
    drive8(3'd4, 8'hD1, 1'b0, 1'b1);
    tick();
    chk("mid_locked", 32'(lk8), 32'h1);
    chk("mid_data4", 32'(d8_out[4]), 32'hD1);
    drive8(3'd0, 8'h00, 1'b0, 1'b0);
    r8_out = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v8_out), 32'h0);
    chk("arst_locked", 32'(lk8), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r8_out = 8'hFF;
    drive8(3'd2, 8'hF2, 1'b1, 1'b1);
    tick();
    chk("post_rst_valid", 32'(v8_out), 32'h04);
    chk("post_rst_data", 32'(d8_out[2]), 32'hF2);
    chk("post_rst_locked", 32'(lk8), 32'h0);
    drive8(3'd0, 8'h00, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Valid/ready stream demultiplexer: the write-side counterpart of the team's N:1 mux. It routes one input stream to one of NUM_OUTPUTS output channels.
- Each output channel has a one-entry registered slot.
- The route is locked per packet: sel is sampled on the first beat and held until the beat carrying in_last.
- It sits between the host-side packet source and the per-peripheral channel FIFOs.

Parameters:
NUM_OUTPUTS, 8, number of output channels (≥2; need not be a power of two)
WIDTH_DATA, 8, data beat width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
in_data  input  WIDTH_DATA  input beat
in_valid  input  1  input beat valid
in_last  input  1  final beat of packet
in_ready  output  1  input beat accepted when in_valid & in_ready
sel  input  $clog2(NUM_OUTPUTS)  destination channel, sampled only on first beat of packet
out_data  output  [NUM_OUTPUTS-1:0][WIDTH_DATA-1:0]  per-channel registered data
out_valid  output  NUM_OUTPUTS  per-channel slot full
out_last  output  NUM_OUTPUTS  per-channel last flag of held beat
out_ready  input  NUM_OUTPUTS  per-channel downstream accept
locked  output  1  high while mid-packet (route locked)
drop  output  1  one-cycle pulse when a beat is discarded for out-of-range route

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; route=0.
  - All out_valid, out_last, out_data = 0.
  - locked=0, drop=0.
- FSM states are IDLE and LOCKED.
  - Effective route: in IDLE it is sel; in LOCKED it is the registered route.
  - IDLE: on an accepted beat with in_last=0, capture route<=sel and go to LOCKED. With in_last=1 (single-beat packet), stay in IDLE.
  - LOCKED: sel is ignored. An accepted beat with in_last=1 returns to IDLE.
  - locked = (state==LOCKED).
- Slot k is free when out_valid[k]=0 or out_ready[k]=1 (drain and reload in the same cycle).
- in_ready is combinational:
  - High if the effective route is valid and slot[route] is free.
  - High if the effective route is ≥ NUM_OUTPUTS (drop path).
  - This is the only combinational path from out_ready to in_ready.
- Accepted beat, valid route: next cycle out_valid[route]=1, out_data[route]=in_data, out_last[route]=in_last. Latency is 1 cycle.
- Slot k with no load and out_valid[k]&out_ready[k] clears out_valid[k]. out_data[k] and out_last[k] hold their last value.
- At most one slot loads per cycle. Other slots drain independently and concurrently.
- Throughput: 1 beat/cycle sustained when the target out_ready is held high.
- Out-of-range route (only when NUM_OUTPUTS is not a power of two):
  - The beat is accepted and discarded; drop pulses high in the next cycle.
  - The FSM still tracks in_last, so the whole packet is dropped.
- A beat on channel j never waits for a stalled channel k≠j, except within the same packet.
- Reset mid-packet: state forced to IDLE and all slots emptied (beats in slots are lost). The next accepted beat is treated as a packet start.
- in_valid deasserting mid-packet keeps LOCKED and keeps the route.

Decomposition:
- Package stream_demux_pkg holds:
  - typedef enum logic {IDLE, LOCKED} demux_state_t
  - a function for sel width, $clog2 with a minimum of 1
- Sub-module stream_slot is one-entry register slice (load, data, last, valid/ready drain, free flag). It is instantiated NUM_OUTPUTS times via generate.
- Top level holds the FSM, route register and ready/drop logic.

Test Plan:
1. Routing sweep: N=8, W=8, out_ready all 1. Send single-beat packets with sel=s, data=8'h10+s, for s=0..7 → one cycle later only out_valid[s]=1 with out_data[s]=8'h10+s. drop never asserts.
2. Packet lock: sel=3 on beat 0 of a 4-beat packet (data A0..A3), then sel=5 on beats 1–3 → all beats appear on channel 3 in order. out_last[3]=1 only with A3. locked goes 1 after A0 and 0 after A3.
3. Backpressure: out_ready[2]=0, send two beats to channel 2 → first held in the slot. in_ready=0 while the second is presented. Raise out_ready[2] → second beat loads in the same cycle the first drains, no bubble, no loss.
4. Independence: out_ready[1]=0 with the slot full; send a beat to channel 6 → accepted immediately, out_valid[6]=1 next cycle, channel 1 undisturbed.
5. Out-of-range: N=6. Send a 2-beat packet with sel=7 → in_ready=1, drop pulses once per beat, no out_valid. The following packet with sel=0 routes correctly.
6. Reset mid-packet: assert rst_n=0 asynchronously (off clock edge) after beat 1 of a 3-beat packet to channel 4 → out_valid=0 and locked=0 immediately. After release, a beat with sel=2 routes to channel 2.
